sobel_edge_stage: RTL and testbench

//  Consumes the RGB pixel stream produced by the camera capture top and converts each

---
 rtl/sobel_edge_stage.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sobel_edge_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_stage.sv
`default_nettype none
// ============================================================================
// Module   : sobel_edge_stage
// Purpose  : Converts an RGB pixel stream to 8-bit luma, buffers two image
//            lines, forms a 3x3 window and produces the saturated Sobel
//            gradient magnitude |Gx|+|Gy| plus a thresholded edge flag for
//            every interior pixel of the frame.
// Ports    : sys_clk_i     - system clock, rising edge
//            sys_rst_i     - synchronous active-high reset
//            cam_red_i     - 8-bit red, qualified by pix_valid_i
//            cam_green_i   - 8-bit green
//            cam_blue_i    - 8-bit blue
//            pix_valid_i   - one pixel beat this cycle (no backpressure)
//            sof_i         - with pix_valid_i: beat is pixel (0,0) of a frame
//            mag_o         - min(|Gx|+|Gy|, 255) at the window centre
//            edge_o        - mag_o >= THRESH
//            out_x_o       - centre column, 1..IMG_W-2
//            out_y_o       - centre row, 1..IMG_H-2
//            out_valid_o   - output fields valid this cycle
//            frame_done_o  - pulse with the output for the last interior pixel
// Revision : 1.0 - initial release
// ============================================================================
module sobel_edge_stage #(
    parameter  int IMG_W  = 640,
    parameter  int IMG_H  = 480,
    parameter  int THRESH = 64,
    localparam int X_W    = $clog2(IMG_W),
    localparam int Y_W    = $clog2(IMG_H)
) (
    input  logic           sys_clk_i,
    input  logic           sys_rst_i,
    input  logic [7:0]     cam_red_i,
    input  logic [7:0]     cam_green_i,
    input  logic [7:0]     cam_blue_i,
    input  logic           pix_valid_i,
    input  logic           sof_i,
    output logic [7:0]     mag_o,
    output logic           edge_o,
    output logic [X_W-1:0] out_x_o,
    output logic [Y_W-1:0] out_y_o,
    output logic           out_valid_o,
    output logic           frame_done_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [X_W-1:0] c_COL_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] c_ROW_LAST = Y_W'(IMG_H - 1);
    localparam logic [X_W-1:0] c_COL_TWO  = X_W'(2);
    localparam logic [Y_W-1:0] c_ROW_TWO  = Y_W'(2);
    localparam logic [X_W-1:0] c_COL_ONE  = X_W'(1);
    localparam logic [Y_W-1:0] c_ROW_ONE  = Y_W'(1);
    localparam logic [7:0]     c_THRESH   = 8'(THRESH);

    // BT.601-style luma weights scaled by 256; they sum to exactly 256 so a
    // gray input maps to itself.
    localparam logic [15:0]    c_KR       = 16'd77;
    localparam logic [15:0]    c_KG       = 16'd150;
    localparam logic [15:0]    c_KB       = 16'd29;

    // ------------------------------------------------------------------------
    // Stage 1 : beat acceptance, position counters, luma
    // ------------------------------------------------------------------------
    logic           r_frame_started;
    logic [X_W-1:0] r_col;          // position of the next accepted beat
    logic [Y_W-1:0] r_row;

    logic           r_s1_valid;
    logic [7:0]     r_s1_luma;
    logic [X_W-1:0] r_s1_col;
    logic [Y_W-1:0] r_s1_row;

    logic           w_accept;
    logic [X_W-1:0] w_cur_col;
    logic [Y_W-1:0] w_cur_row;
    logic [X_W-1:0] w_next_col;
    logic [Y_W-1:0] w_next_row;
    logic [15:0]    w_luma_sum;

    // Beats before the first start-of-frame carry no usable position.
    assign w_accept   = pix_valid_i & (sof_i | r_frame_started);

    // A start-of-frame beat always lands at (0,0), whatever the counters say.
    assign w_cur_col  = sof_i ? '0 : r_col;
    assign w_cur_row  = sof_i ? '0 : r_row;

    always_comb begin
        w_next_col = w_cur_col + c_COL_ONE;
        w_next_row = w_cur_row;
        if (w_cur_col == c_COL_LAST) begin
            w_next_col = '0;
            if (w_cur_row == c_ROW_LAST) begin
                w_next_row = '0;
            end else begin
                w_next_row = w_cur_row + c_ROW_ONE;
            end
        end
    end

    assign w_luma_sum = c_KR * {8'd0, cam_red_i}
                      + c_KG * {8'd0, cam_green_i}
                      + c_KB * {8'd0, cam_blue_i};

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_frame_started <= 1'b0;
            r_col           <= '0;
            r_row           <= '0;
            r_s1_valid      <= 1'b0;
            r_s1_luma       <= '0;
            r_s1_col        <= '0;
            r_s1_row        <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (pix_valid_i && sof_i) begin
                r_frame_started <= 1'b1;
            end
            if (w_accept) begin
                r_col     <= w_next_col;
                r_row     <= w_next_row;
                r_s1_luma <= w_luma_sum[15:8];
                r_s1_col  <= w_cur_col;
                r_s1_row  <= w_cur_row;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 : line buffers and 3x3 window
    // ------------------------------------------------------------------------
    // r_lb1 holds line r-1, r_lb2 holds line r-2. Both are read and written at
    // the same column: the old contents are read out for the window while the
    // lines shift down by one. Contents are not reset; rows 0 and 1 of a frame
    // read stale data, but those windows are never reported.
    logic [7:0]     r_lb1 [IMG_W];
    logic [7:0]     r_lb2 [IMG_W];
    logic [7:0]     w_lb1_rd;
    logic [7:0]     w_lb2_rd;

    assign w_lb1_rd = r_lb1[r_s1_col];
    assign w_lb2_rd = r_lb2[r_s1_col];

    always_ff @(posedge sys_clk_i) begin
        if (r_s1_valid) begin
            r_lb1[r_s1_col] <= r_s1_luma;
            r_lb2[r_s1_col] <= w_lb1_rd;
        end
    end

    // r_win[i][j]: row i (0 = oldest line), column j (0 = leftmost).
    logic [7:0]     r_win [3][3];
    logic           r_s2_valid;
    logic           r_s2_last;
    logic [X_W-1:0] r_s2_x;
    logic [Y_W-1:0] r_s2_y;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_x     <= '0;
            r_s2_y     <= '0;
        end else begin
            // The window only moves on real beats, so idle cycles upstream
            // never smear a column into it.
            if (r_s1_valid) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb2_rd;
                r_win[1][2] <= w_lb1_rd;
                r_win[2][2] <= r_s1_luma;
            end
            // Only beats at col>=2, row>=2 complete a window lying fully
            // inside the frame; its centre is one column and one row back.
            r_s2_valid <= r_s1_valid && (r_s1_col >= c_COL_TWO)
                                     && (r_s1_row >= c_ROW_TWO);
            r_s2_last  <= (r_s1_col == c_COL_LAST) && (r_s1_row == c_ROW_LAST);
            r_s2_x     <= r_s1_col - c_COL_ONE;
            r_s2_y     <= r_s1_row - c_ROW_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3 : horizontal and vertical gradients
    // ------------------------------------------------------------------------
    // Each weighted column/row sum is at most 4*255 = 1020 (10 bits). The
    // difference is taken in 11 bits and kept as two's complement.
    logic [9:0]     w_gx_pos;
    logic [9:0]     w_gx_neg;
    logic [9:0]     w_gy_pos;
    logic [9:0]     w_gy_neg;
    logic [10:0]    w_gx;
    logic [10:0]    w_gy;

    assign w_gx_pos = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
    assign w_gx_neg = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
    assign w_gy_pos = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
    assign w_gy_neg = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};
    assign w_gx     = {1'b0, w_gx_pos} - {1'b0, w_gx_neg};
    assign w_gy     = {1'b0, w_gy_pos} - {1'b0, w_gy_neg};

    logic           r_s3_valid;
    logic           r_s3_last;
    logic [X_W-1:0] r_s3_x;
    logic [Y_W-1:0] r_s3_y;
    logic [10:0]    r_s3_gx;
    logic [10:0]    r_s3_gy;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_x     <= '0;
            r_s3_y     <= '0;
            r_s3_gx    <= '0;
            r_s3_gy    <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_valid & r_s2_last;
            r_s3_x     <= r_s2_x;
            r_s3_y     <= r_s2_y;
            r_s3_gx    <= w_gx;
            r_s3_gy    <= w_gy;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 4 : magnitude, saturation, threshold, outputs
    // ------------------------------------------------------------------------
    logic [10:0]    w_abs_gx;
    logic [10:0]    w_abs_gy;
    logic [10:0]    w_sum;
    logic [7:0]     w_mag;

    assign w_abs_gx = r_s3_gx[10] ? (~r_s3_gx + 11'd1) : r_s3_gx;
    assign w_abs_gy = r_s3_gy[10] ? (~r_s3_gy + 11'd1) : r_s3_gy;
    assign w_sum    = w_abs_gx + w_abs_gy;      // at most 2040, no overflow
    assign w_mag    = (|w_sum[10:8]) ? 8'hFF : w_sum[7:0];

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            mag_o        <= '0;
            edge_o       <= 1'b0;
            out_x_o      <= '0;
            out_y_o      <= '0;
            out_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            out_valid_o  <= r_s3_valid;
            frame_done_o <= r_s3_valid & r_s3_last;
            if (r_s3_valid) begin
                mag_o   <= w_mag;
                edge_o  <= (w_mag >= c_THRESH);
                out_x_o <= r_s3_x;
                out_y_o <= r_s3_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_edge_stage
// Purpose  : Directed, table-driven check of sobel_edge_stage on an 8x6 image
//            with THRESH=64. Each table record names an image pattern and
//            the hand-computed magnitude for all 24 interior centres.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_edge_stage;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int TH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] red = '0;
    logic [7:0] grn = '0;
    logic [7:0] blu = '0;
    logic       pv  = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] mag;
    logic       edg;
    logic [2:0] ox;
    logic [2:0] oy;
    logic       ov;
    logic       fd;

    sobel_edge_stage #(
        .IMG_W (W),
        .IMG_H (H),
        .THRESH(TH)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .cam_red_i   (red),
        .cam_green_i (grn),
        .cam_blue_i  (blu),
        .pix_valid_i (pv),
        .sof_i       (sof),
        .mag_o       (mag),
        .edge_o      (edg),
        .out_x_o     (ox),
        .out_y_o     (oy),
        .out_valid_o (ov),
        .frame_done_o(fd)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pattern kinds: 0 = vertical step (cols>=4 take hi),
    // 1 = horizontal step (rows>=3 take hi), 2 = corner (both).
    // m[y-1][x-1] is the required magnitude at centre (x,y).
    typedef struct packed {
        logic [1:0]            kind;
        logic [23:0]           lo;
        logic [23:0]           hi;
        logic [3:0][5:0][7:0]  m;
    } vec_t;

    typedef struct packed {
        logic [2:0]  x;
        logic [2:0]  y;
        logic [7:0]  m;
        logic        e;
        logic        fd;
        logic [31:0] cyc;
    } exp_t;

    localparam int NV = 10;
    vec_t tv [NV];
    exp_t expq [$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [23:0] gray(input logic [7:0] v);
        return {v, v, v};
    endfunction

    function automatic vec_t mk(input logic [1:0] k, input logic [23:0] lo, input logic [23:0] hi);
        vec_t v;
        v.kind = k;
        v.lo   = lo;
        v.hi   = hi;
        v.m    = '0;
        return v;
    endfunction

    task automatic set_row(input int i, input int y, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic [7:0] e,
                           input logic [7:0] f);
        tv[i].m[y][0] = a;
        tv[i].m[y][1] = b;
        tv[i].m[y][2] = c;
        tv[i].m[y][3] = d;
        tv[i].m[y][4] = e;
        tv[i].m[y][5] = f;
    endtask

    task automatic set_all(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic [7:0] e,
                           input logic [7:0] f);
        for (int y = 0; y < 4; y++) set_row(i, y, a, b, c, d, e, f);
    endtask

    function automatic logic [23:0] pixel(input int vi, input int c, input int r);
        logic hi;
        case (tv[vi].kind)
            2'd0:    hi = (c >= 4);
            2'd1:    hi = (r >= 3);
            default: hi = (c >= 4) && (r >= 3);
        endcase
        return hi ? tv[vi].hi : tv[vi].lo;
    endfunction

    // Drives nb beats of pattern vi in raster order starting at (0,0). Beats
    // that complete an interior window queue their required output, stamped
    // with the cycle the beat was presented in.
    task automatic send_frame(input int vi, input int nb, input bit gaps,
                              input bit use_sof, input bit push);
        int   c;
        int   r;
        int   ng;
        exp_t e;
        for (int k = 0; k < nb; k++) begin
            c = k % W;
            r = k / W;
            if (gaps) begin
                ng = int'($urandom_range(0, 2));
                for (int g = 0; g < ng; g++) begin
                    @(negedge clk);
                    pv  = 1'b0;
                    sof = 1'($urandom);
                    {red, grn, blu} = 24'($urandom);
                end
            end
            @(negedge clk);
            pv  = 1'b1;
            sof = use_sof && (k == 0);
            {red, grn, blu} = pixel(vi, c, r);
            if (push && c >= 2 && r >= 2) begin
                e.x   = 3'(c - 1);
                e.y   = 3'(r - 1);
                e.m   = tv[vi].m[r-2][c-2];
                e.e   = (e.m >= 8'(TH));
                e.fd  = (c == W - 1) && (r == H - 1);
                e.cyc = cyc;
                expq.push_back(e);
            end
        end
    endtask

    // A beat presented in cycle n must show up at the output in cycle n+4.
    task automatic check_out();
        exp_t e;
        if (ov === 1'b1) begin
            n_vec++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output got x=%0d y=%0d mag=%0d, required no output",
                         ox, oy, mag);
            end else begin
                e = expq.pop_front();
                if ({ox, oy, mag, edg, fd} !== {e.x, e.y, e.m, e.e, e.fd} || (cyc - e.cyc) != 4) begin
                    n_bad++;
                    $display("FAIL output got x=%0d y=%0d mag=%0d edge=%0d fd=%0d lat=%0d, required x=%0d y=%0d mag=%0d edge=%0d fd=%0d lat=4",
                             ox, oy, mag, edg, fd, cyc - e.cyc, e.x, e.y, e.m, e.e, e.fd);
                end
            end
        end else if (fd !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_done_alone got fd=%b valid=%b, required fd=0", fd, ov);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        @(negedge clk);
        pv  = 1'b0;
        sof = 1'b0;
        while (expq.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (8) @(negedge clk);
        n_vec++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL %s missing_outputs got %0d outstanding, required 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic check_reset(input string name);
        n_vec++;
        if ({ov, fd, edg, mag, ox, oy} !== 15'd0) begin
            n_bad++;
            $display("FAIL %s got valid=%b fd=%b edge=%b mag=%0d x=%0d y=%0d, required all 0",
                     name, ov, fd, edg, mag, ox, oy);
        end
    endtask

    initial begin
        // Flat and vertical steps: identical per row.
        tv[0] = mk(2'd0, gray(8'd100), gray(8'd100));
        set_all(0, 8'd0, 8'd0, 8'd0,   8'd0,   8'd0, 8'd0);
        tv[1] = mk(2'd0, gray(8'd0), gray(8'd255));
        set_all(1, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0);
        tv[2] = mk(2'd0, gray(8'd0), gray(8'd10));
        set_all(2, 8'd0, 8'd0, 8'd40,  8'd40,  8'd0, 8'd0);
        tv[3] = mk(2'd0, gray(8'd0), gray(8'd20));
        set_all(3, 8'd0, 8'd0, 8'd80,  8'd80,  8'd0, 8'd0);
        // Red 255 -> Y=76, 4*76=304 saturates.
        tv[4] = mk(2'd0, 24'h000000, 24'hFF0000);
        set_all(4, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0);
        // Blue 255 -> Y=28, 4*28=112.
        tv[5] = mk(2'd0, 24'h000000, 24'h0000FF);
        set_all(5, 8'd0, 8'd0, 8'd112, 8'd112, 8'd0, 8'd0);
        // Falling step: negative Gx.
        tv[6] = mk(2'd0, gray(8'd255), gray(8'd0));
        set_all(6, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0);
        // Horizontal step 0|10: Gy only, on rows y=2,3.
        tv[7] = mk(2'd1, gray(8'd0), gray(8'd10));
        set_row(7, 0, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0);
        set_row(7, 1, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40);
        set_row(7, 2, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40);
        set_row(7, 3, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0);
        // Corner, v=11: peak 6v=66 at (4,3) just over threshold.
        tv[8] = mk(2'd2, gray(8'd0), gray(8'd11));
        set_row(8, 0, 8'd0, 8'd0, 8'd0,  8'd0,  8'd0,  8'd0);
        set_row(8, 1, 8'd0, 8'd0, 8'd22, 8'd44, 8'd44, 8'd44);
        set_row(8, 2, 8'd0, 8'd0, 8'd44, 8'd66, 8'd44, 8'd44);
        set_row(8, 3, 8'd0, 8'd0, 8'd44, 8'd44, 8'd0,  8'd0);
        // Corner, v=10: peak 60 just under threshold.
        tv[9] = mk(2'd2, gray(8'd0), gray(8'd10));
        set_row(9, 0, 8'd0, 8'd0, 8'd0,  8'd0,  8'd0,  8'd0);
        set_row(9, 1, 8'd0, 8'd0, 8'd20, 8'd40, 8'd40, 8'd40);
        set_row(9, 2, 8'd0, 8'd0, 8'd40, 8'd60, 8'd40, 8'd40);
        set_row(9, 3, 8'd0, 8'd0, 8'd40, 8'd40, 8'd0,  8'd0);

        // Reset held with random activity on the inputs.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pv  = 1'($urandom);
            sof = 1'($urandom);
            {red, grn, blu} = 24'($urandom);
            @(negedge clk);
            check_reset("reset_hold");
        end
        rst = 1'b0;
        pv  = 1'b0;
        sof = 1'b0;

        fork
            forever begin
                @(negedge clk);
                check_out();
            end
        join_none

        // Whole-frame table, continuous valid.
        for (int i = 0; i < NV; i++) begin
            send_frame(i, W * H, 1'b0, 1'b1, 1'b1);
            drain($sformatf("vec%0d", i));
        end

        // Random idle gaps (with stray sof on idle cycles).
        send_frame(1, W * H, 1'b1, 1'b1, 1'b1);
        drain("gaps_vstep");
        send_frame(8, W * H, 1'b1, 1'b1, 1'b1);
        drain("gaps_corner");

        // Start-of-frame after three rows: row-2 results of the old frame
        // drain, then the new frame restarts from (0,0).
        send_frame(1, 3 * W, 1'b0, 1'b1, 1'b1);
        send_frame(3, W * H, 1'b0, 1'b1, 1'b1);
        drain("sof_restart");

        // Reset mid-frame drops in-flight results; beats without a new sof
        // are discarded until a sof arrives.
        send_frame(6, 2 * W + 4, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        pv  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("reset_mid");
        send_frame(1, W * H, 1'b0, 1'b0, 1'b0);
        drain("no_sof_after_reset");
        send_frame(2, W * H, 1'b0, 1'b1, 1'b1);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
